quant_writeback_ctrl: RTL and testbench
=======================================

# quant_writeback_ctrl

Sequences the drain of the systolic array's accumulator rows through per-lane saturating quantization into the output SRAM. One row of ARRAY_SIZE wide accumulators (2*DATA_WIDTH+5 bits each) is selected per step, clipped to OUTPUT_DATA_WIDTH signed lanes, registered, and written at an incrementing address under SRAM backpressure. After the last row it pulses an accumulator clear to the array and a done to the top-level controller. It also counts clipped lanes for debug and quality monitoring.

## Interface
- ARRAY_SIZE, 8, rows per tile and lanes per row
- DATA_WIDTH, 8, operand width; accumulator lane width ACC_W = 2*DATA_WIDTH+5
- OUTPUT_DATA_WIDTH, 16, quantized lane width
- ADDR_WIDTH, 10, output SRAM address width
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to drain one tile; honoured only in IDLE
- base_addr  in  ADDR_WIDTH  first SRAM address, sampled with accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, coincident with acc_clear
- row_sel  out  clog2(ARRAY_SIZE)  accumulator row presented on acc_data
- acc_data  in  ARRAY_SIZE*ACC_W  selected row, combinational from row_sel, signed lanes, lane i at [i*ACC_W +: ACC_W]
- acc_clear  out  1  one-cycle pulse telling the array to zero its accumulators
- sram_wen  out  1  write request, active high
- sram_ready  in  1  SRAM accepts the write this cycle when high with sram_wen
- sram_waddr  out  ADDR_WIDTH  write address
- sram_wdata  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantized row, lane i at [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
- sat_cnt  out  16  clipped lanes since last accepted start

## Operation
- Quantization per lane: QMAX = 2^(OUTPUT_DATA_WIDTH-1)-1 and QMIN = -2^(OUTPUT_DATA_WIDTH-1). A value >= QMAX maps to QMAX, a value <= QMIN maps to QMIN, and any other value maps to its low OUTPUT_DATA_WIDTH bits.
- Clip flag per lane: set when the value is strictly > QMAX or strictly < QMIN. Exact QMAX/QMIN do not count.
- FSM states: IDLE, FILL, WRITE, CLEAR.
- IDLE: on start, load waddr <= base_addr, rd_row <= 0, wr_row <= 0 and sat_cnt <= 0, then go to FILL. Without start, stay in IDLE.
- FILL, one cycle: row_sel = rd_row = 0. Capture the quantized acc_data into the wdata register, add that row's clip count to sat_cnt, set rd_row <= 1, then go to WRITE.
- WRITE: sram_wen = 1; sram_waddr and sram_wdata come from registers; row_sel = rd_row.
  - A write is accepted when sram_ready = 1. On acceptance, waddr increments and wraps modulo 2^ADDR_WIDTH.
  - If wr_row == ARRAY_SIZE-1 at acceptance, go to CLEAR.
  - Otherwise, on acceptance, capture the next quantized row into wdata, accumulate its clips, and increment rd_row and wr_row. This gives one row per cycle when there is no backpressure.
  - When sram_ready = 0, every register holds and the outputs stay stable.
- CLEAR, one cycle: acc_clear = 1, done = 1, then go to IDLE.
- start outside IDLE is ignored. It is not queued.
- sat_cnt saturates at 0xFFFF and holds its value after done until the next accepted start.

## Timing
- Reset: state IDLE; busy, done, acc_clear and sram_wen = 0; row_sel, sram_waddr, sram_wdata and sat_cnt = 0.
- rst mid-operation aborts immediately. No acc_clear and no done are issued.
- sram_wen, acc_clear, done and busy are decoded from state only. They have no combinational path from sram_ready.
- Cycle numbering with start sampled at cycle 0:
  - cycle 1: FILL.
  - cycle 2: first write presented.
  - with sram_ready held high, row k is presented at cycle 2+k.
  - cycle ARRAY_SIZE+2: CLEAR/done.
  - Each cycle with sram_ready low during WRITE adds exactly one cycle.
- start is accepted again in the cycle after CLEAR, so the minimum start-to-start interval is ARRAY_SIZE+3 cycles.

## Structure
- Shared package `quant_pkg` holds:
  - the state encoding (IDLE, FILL, WRITE, CLEAR);
  - the ACC_W, QMAX and QMIN derivations as functions of the parameters;
  - the sat_cnt width.
- Sub-module `quant_sat_lane`, purely combinational, one instance per lane: ACC_W-bit signed input, OUTPUT_DATA_WIDTH-bit output plus a clip flag. The controller sums the ARRAY_SIZE clip flags with a popcount.

## Test plan
- Tile with row r, lane i = r*256+i, sram_ready held high: 8 writes at addresses base..base+7 on cycles 2..9, each lane equal to its input, done/acc_clear at cycle 10, sat_cnt = 0.
- Lanes 40000, -40000, 32767, -32768 and 32766: outputs 32767, -32768, 32767, -32768 and 32766; sat_cnt increments by 2 per row.
- sram_ready low for 3 cycles during row 3: wen, waddr and wdata stay stable and row_sel stays at 4; done arrives 3 cycles later at cycle 13; no row is lost or duplicated.
- base_addr = 2^ADDR_WIDTH-3: addresses wrap to 0 after the maximum address; all 8 rows are written.
- start pulsed during WRITE is ignored. rst asserted in WRITE gives all outputs 0 in the next cycle, and acc_clear never pulses.
- Back-to-back: start asserted in the cycle after done; the second tile begins FILL in the following cycle and sat_cnt is cleared.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared types and derivations for the accumulator writeback path.
// State encoding, lane widths, saturation bounds, counter width.
package quant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    localparam int SAT_CNT_W = 16;

    function automatic int acc_w(input int data_width);
        return 2 * data_width + 5;
    endfunction

    function automatic longint qmax(input int out_width);
        return (longint'(1) <<< (out_width - 1)) - 1;
    endfunction

    function automatic longint qmin(input int out_width);
        return -(longint'(1) <<< (out_width - 1));
    endfunction

endpackage

// File: rtl/quant_writeback_ctrl_sat_lane.sv
// One saturating quantizer lane: signed ACC_W in, signed OUT_W out.
// Ports: acc_in (accumulator), q_out (clipped value), clip (value out of range).
module quant_sat_lane
    import quant_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic        [OUT_W-1:0] q_out,
    output logic                    clip
);

    localparam logic signed [ACC_W-1:0] QMAX_A = ACC_W'(qmax(OUT_W));
    localparam logic signed [ACC_W-1:0] QMIN_A = ACC_W'(qmin(OUT_W));

    // Exact bounds map to themselves but are not counted as clipped.
    always_comb begin
        q_out = acc_in[OUT_W-1:0];
        clip  = 1'b0;
        if (acc_in >= QMAX_A) begin
            q_out = QMAX_A[OUT_W-1:0];
            clip  = (acc_in > QMAX_A);
        end else if (acc_in <= QMIN_A) begin
            q_out = QMIN_A[OUT_W-1:0];
            clip  = (acc_in < QMIN_A);
        end
    end

endmodule

// File: rtl/quant_writeback_ctrl.sv
// Drains accumulator rows through per-lane quantizers into output SRAM.
// Ports: start/base_addr in, busy/done/acc_clear out, row_sel/acc_data
// array side, sram_wen/ready/waddr/wdata SRAM side, sat_cnt clip count.
module quant_writeback_ctrl
    import quant_pkg::*;
#(
    parameter int ARRAY_SIZE        = 8,
    parameter int DATA_WIDTH        = 8,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    output logic                                      busy,
    output logic                                      done,
    output logic [$clog2(ARRAY_SIZE)-1:0]             row_sel,
    input  logic [ARRAY_SIZE*acc_w(DATA_WIDTH)-1:0]   acc_data,
    output logic                                      acc_clear,
    output logic                                      sram_wen,
    input  logic                                      sram_ready,
    output logic [ADDR_WIDTH-1:0]                     sram_waddr,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_wdata,
    output logic [SAT_CNT_W-1:0]                      sat_cnt
);

    localparam int ACC_W = acc_w(DATA_WIDTH);
    localparam int OW    = OUTPUT_DATA_WIDTH;
    localparam int RW    = $clog2(ARRAY_SIZE);
    localparam int CW    = $clog2(ARRAY_SIZE + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_SIZE - 1);

    state_e                     state_q, state_d;
    logic [RW-1:0]              rd_row_q, rd_row_d;
    logic [RW-1:0]              wr_row_q, wr_row_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [ARRAY_SIZE*OW-1:0]   wdata_q, wdata_d;
    logic [SAT_CNT_W-1:0]       sat_q, sat_d;

    logic [ARRAY_SIZE*OW-1:0]   q_row;
    logic [ARRAY_SIZE-1:0]      clip;
    logic [CW-1:0]              clip_cnt;
    logic [SAT_CNT_W:0]         sat_sum;
    logic [SAT_CNT_W-1:0]       sat_add;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        quant_sat_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OW)
        ) u_lane (
            .acc_in (acc_data[i*ACC_W +: ACC_W]),
            .q_out  (q_row[i*OW +: OW]),
            .clip   (clip[i])
        );
    end

    always_comb begin
        clip_cnt = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            clip_cnt = clip_cnt + CW'(clip[i]);
        end
    end

    // One extra bit catches the carry so the count sticks at all-ones.
    assign sat_sum = {1'b0, sat_q} + (SAT_CNT_W+1)'(clip_cnt);
    assign sat_add = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];

    always_comb begin
        state_d  = state_q;
        rd_row_d = rd_row_q;
        wr_row_d = wr_row_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sat_d    = sat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    waddr_d  = base_addr;
                    rd_row_d = '0;
                    wr_row_d = '0;
                    sat_d    = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                wdata_d  = q_row;
                sat_d    = sat_add;
                rd_row_d = rd_row_q + 1'b1;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (sram_ready) begin
                    waddr_d = waddr_q + 1'b1;
                    if (wr_row_q == LAST_ROW) begin
                        state_d = ST_CLEAR;
                    end else begin
                        // Prefetch the next row while this one retires.
                        wdata_d  = q_row;
                        sat_d    = sat_add;
                        rd_row_d = rd_row_q + 1'b1;
                        wr_row_d = wr_row_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_row_q <= '0;
            wr_row_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            sat_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_row_q <= rd_row_d;
            wr_row_q <= wr_row_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            sat_q    <= sat_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sram_wen   = (state_q == ST_WRITE);
    assign acc_clear  = (state_q == ST_CLEAR);
    assign done       = (state_q == ST_CLEAR);
    assign row_sel    = rd_row_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign sat_cnt    = sat_q;

endmodule

// File: tb/tb_quant_writeback_ctrl.sv
// Directed bench for quant_writeback_ctrl.
// Array rows are modelled by a table driven onto acc_data from row_sel.
module tb_quant_writeback_ctrl;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int AW    = 10;
    localparam int ACC_W = 2 * DW + 5;
    localparam int RW    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic              busy;
    logic              done;
    logic [RW-1:0]     row_sel;
    logic [N*ACC_W-1:0] acc_data;
    logic              acc_clear;
    logic              sram_wen;
    logic              sram_ready;
    logic [AW-1:0]     sram_waddr;
    logic [N*OW-1:0]   sram_wdata;
    logic [15:0]       sat_cnt;

    int tests  = 0;
    int failed = 0;

    int tile [N][N];

    int            n_wr;
    int            done_cyc;
    int            clr_cnt;
    logic [AW-1:0] cap_addr [16];
    logic [N*OW-1:0] cap_data [16];
    int            cap_cyc  [16];
    logic          obs_wen  [40];
    logic [AW-1:0] obs_addr [40];
    logic [N*OW-1:0] obs_data [40];
    logic [RW-1:0] obs_rsel [40];
    logic [15:0]   obs_sat  [40];

    quant_writeback_ctrl #(
        .ARRAY_SIZE        (N),
        .DATA_WIDTH        (DW),
        .OUTPUT_DATA_WIDTH (OW),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .row_sel    (row_sel),
        .acc_data   (acc_data),
        .acc_clear  (acc_clear),
        .sram_wen   (sram_wen),
        .sram_ready (sram_ready),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        acc_data = '0;
        for (int i = 0; i < N; i++) begin
            acc_data[i*ACC_W +: ACC_W] = ACC_W'(tile[row_sel][i]);
        end
    end

    function automatic logic [N*OW-1:0] row_basic(input int k);
        logic [N*OW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*OW +: OW] = OW'(k * 256 + i);
        return r;
    endfunction

    localparam logic [N*OW-1:0] ROW_SAT = {16'hFFFF, 16'h0001, 16'h0000,
        16'h7FFE, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};

    task automatic set_tile_basic();
        for (int r = 0; r < N; r++)
            for (int i = 0; i < N; i++) tile[r][i] = r * 256 + i;
    endtask

    task automatic set_tile_sat();
        for (int r = 0; r < N; r++) begin
            tile[r][0] = 40000;
            tile[r][1] = -40000;
            tile[r][2] = 32767;
            tile[r][3] = -32768;
            tile[r][4] = 32766;
            tile[r][5] = 0;
            tile[r][6] = 1;
            tile[r][7] = -1;
        end
    endtask

    // Pulses start; returns at the negedge of cycle 1.
    task automatic start_tile(input logic [AW-1:0] base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Observes cycles from 1 until done or the cycle budget runs out.
    task automatic drain(input int stall_at, input int stall_len,
                         input int spur_at);
        n_wr     = 0;
        done_cyc = -1;
        clr_cnt  = 0;
        for (int c = 1; c < 40; c++) begin
            sram_ready = !(c >= stall_at && c < stall_at + stall_len);
            start      = (c == spur_at);
            if (c == spur_at) base_addr = 10'd500;
            obs_wen[c]  = sram_wen;
            obs_addr[c] = sram_waddr;
            obs_data[c] = sram_wdata;
            obs_rsel[c] = row_sel;
            obs_sat[c]  = sat_cnt;
            if (sram_wen && sram_ready && n_wr < 16) begin
                cap_addr[n_wr] = sram_waddr;
                cap_data[n_wr] = sram_wdata;
                cap_cyc[n_wr]  = c;
                n_wr++;
            end
            if (acc_clear) clr_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        sram_ready = 1'b1;
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, acc_clear, sram_wen} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {busy, done, acc_clear, sram_wen});
        end
        tests++;
        if (row_sel !== 3'd0 || sram_waddr !== 10'd0) begin
            failed++;
            $display("FAIL reset_addr: got row_sel %0d waddr %0d want 0 0",
                     row_sel, sram_waddr);
        end
        tests++;
        if (sram_wdata !== '0 || sat_cnt !== 16'd0) begin
            failed++;
            $display("FAIL reset_data: got wdata %h sat %0d want 0 0",
                     sram_wdata, sat_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        set_tile_basic();
        start_tile(10'd16);
        tests++;
        if (busy !== 1'b1 || sram_wen !== 1'b0) begin
            failed++;
            $display("FAIL basic_fill: got busy %b wen %b want 1 0",
                     busy, sram_wen);
        end
        drain(0, 0, -1);
        tests++;
        if (n_wr !== 8) begin
            failed++;
            $display("FAIL basic_nwr: got %0d want 8", n_wr);
        end
        for (int k = 0; k < 8 && k < n_wr; k++) begin
            tests++;
            if (cap_addr[k] !== AW'(16 + k) || cap_cyc[k] !== 2 + k ||
                cap_data[k] !== row_basic(k)) begin
                failed++;
                $display("FAIL basic_row%0d: got a%0d c%0d d%h want a%0d c%0d d%h",
                         k, cap_addr[k], cap_cyc[k], cap_data[k],
                         16 + k, 2 + k, row_basic(k));
            end
        end
        tests++;
        if (done_cyc !== 10 || clr_cnt !== 1) begin
            failed++;
            $display("FAIL basic_done: got cyc %0d clr %0d want 10 1",
                     done_cyc, clr_cnt);
        end
        tests++;
        if (sat_cnt !== 16'd0) begin
            failed++;
            $display("FAIL basic_sat: got %0d want 0", sat_cnt);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || acc_clear !== 1'b0) begin
            failed++;
            $display("FAIL basic_after: got busy %b done %b clr %b want 0 0 0",
                     busy, done, acc_clear);
        end
    endtask

    task automatic test_saturate();
        set_tile_sat();
        start_tile(10'd40);
        drain(0, 0, -1);
        tests++;
        if (obs_sat[1] !== 16'd0 || obs_sat[2] !== 16'd2 ||
            obs_sat[3] !== 16'd4) begin
            failed++;
            $display("FAIL sat_step: got %0d %0d %0d want 0 2 4",
                     obs_sat[1], obs_sat[2], obs_sat[3]);
        end
        tests++;
        if (n_wr !== 8 || cap_data[0] !== ROW_SAT || cap_data[7] !== ROW_SAT) begin
            failed++;
            $display("FAIL sat_data: got n%0d %h %h want 8 %h",
                     n_wr, cap_data[0], cap_data[7], ROW_SAT);
        end
        tests++;
        if (sat_cnt !== 16'd16) begin
            failed++;
            $display("FAIL sat_total: got %0d want 16", sat_cnt);
        end
    endtask

    task automatic test_backpressure();
        set_tile_basic();
        start_tile(10'd100);
        drain(5, 3, -1);
        tests++;
        if (done_cyc !== 13 || n_wr !== 8) begin
            failed++;
            $display("FAIL bp_done: got cyc %0d n%0d want 13 8", done_cyc, n_wr);
        end
        for (int k = 0; k < 8 && k < n_wr; k++) begin
            tests++;
            if (cap_addr[k] !== AW'(100 + k) || cap_data[k] !== row_basic(k)) begin
                failed++;
                $display("FAIL bp_row%0d: got a%0d d%h want a%0d d%h",
                         k, cap_addr[k], cap_data[k], 100 + k, row_basic(k));
            end
        end
        for (int c = 5; c <= 8; c++) begin
            tests++;
            if (obs_wen[c] !== 1'b1 || obs_addr[c] !== 10'd103 ||
                obs_data[c] !== row_basic(3) || obs_rsel[c] !== 3'd4) begin
                failed++;
                $display("FAIL bp_hold_c%0d: got w%b a%0d r%0d want 1 103 4",
                         c, obs_wen[c], obs_addr[c], obs_rsel[c]);
            end
        end
    endtask

    task automatic test_wrap();
        set_tile_basic();
        start_tile(10'd1021);
        drain(0, 0, -1);
        tests++;
        if (n_wr !== 8 || done_cyc !== 10) begin
            failed++;
            $display("FAIL wrap_count: got n%0d cyc %0d want 8 10", n_wr, done_cyc);
        end
        for (int k = 0; k < 8 && k < n_wr; k++) begin
            tests++;
            if (cap_addr[k] !== AW'((1021 + k) % 1024) ||
                cap_data[k] !== row_basic(k)) begin
                failed++;
                $display("FAIL wrap_row%0d: got a%0d want a%0d",
                         k, cap_addr[k], (1021 + k) % 1024);
            end
        end
    endtask

    task automatic test_start_ignored();
        set_tile_basic();
        start_tile(10'd200);
        drain(0, 0, 4);
        tests++;
        if (done_cyc !== 10 || n_wr !== 8 || cap_addr[0] !== 10'd200 ||
            cap_addr[7] !== 10'd207) begin
            failed++;
            $display("FAIL ign_run: got cyc %0d n%0d a0 %0d a7 %0d want 10 8 200 207",
                     done_cyc, n_wr, cap_addr[0], cap_addr[7]);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL ign_idle1: got busy %b want 0", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL ign_idle2: got busy %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        set_tile_sat();
        start_tile(10'd0);
        drain(0, 0, -1);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 10'd300;
        set_tile_basic();
        tests++;
        if (busy !== 1'b0 || sat_cnt !== 16'd16) begin
            failed++;
            $display("FAIL b2b_hold: got busy %b sat %0d want 0 16", busy, sat_cnt);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || sram_wen !== 1'b0 || sat_cnt !== 16'd0) begin
            failed++;
            $display("FAIL b2b_fill: got busy %b wen %b sat %0d want 1 0 0",
                     busy, sram_wen, sat_cnt);
        end
        drain(0, 0, -1);
        tests++;
        if (done_cyc !== 10 || n_wr !== 8 || cap_addr[0] !== 10'd300 ||
            cap_data[7] !== row_basic(7) || sat_cnt !== 16'd0) begin
            failed++;
            $display("FAIL b2b_run: got cyc %0d n%0d a0 %0d sat %0d want 10 8 300 0",
                     done_cyc, n_wr, cap_addr[0], sat_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int clr_seen;
        int busy_seen;
        set_tile_sat();
        start_tile(10'd50);
        repeat (3) @(negedge clk);
        tests++;
        if (sram_wen !== 1'b1 || sat_cnt === 16'd0) begin
            failed++;
            $display("FAIL rmid_pre: got wen %b sat %0d want 1 nonzero",
                     sram_wen, sat_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, acc_clear, sram_wen} !== 4'b0000 || row_sel !== 3'd0 ||
            sram_waddr !== 10'd0 || sram_wdata !== '0 || sat_cnt !== 16'd0) begin
            failed++;
            $display("FAIL rmid_zero: got ctl %b r%0d a%0d sat %0d want all 0",
                     {busy, done, acc_clear, sram_wen}, row_sel, sram_waddr, sat_cnt);
        end
        rst       = 1'b0;
        clr_seen  = 0;
        busy_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (acc_clear || done) clr_seen++;
            if (busy) busy_seen++;
        end
        tests++;
        if (clr_seen !== 0 || busy_seen !== 0) begin
            failed++;
            $display("FAIL rmid_after: got clr %0d busy %0d want 0 0",
                     clr_seen, busy_seen);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sram_ready = 1'b1;
        base_addr  = '0;
        for (int r = 0; r < N; r++)
            for (int i = 0; i < N; i++) tile[r][i] = 0;
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
